quick_mem_arbiter: RTL and testbench
====================================

// Module: quick_mem_arbiter
// PURPOSE
//   Sole master of the single external memory port (address out, data in) shared by the quick CPU's
//   instruction-fetch and data load/store paths. Arbitrates, sequences address/strobe/sample phases
//   with a fixed read latency, and returns data to the winner. Sits between CPU core and top-level pins.
// PARAMETERS
//   ADDR_W        8  address width
//   DATA_W        8  data width
//   RD_LATENCY    1  cycles mem_addr/strobe held before mem_rdata is sampled (>=1)
//   STARVE_LIMIT  3  consecutive data grants while f_req is pending before fetch is forced to win (>=1)
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   f_req      in   1       fetch request, held until f_gnt
//   f_addr     in   ADDR_W  fetch address, valid with f_req
//   f_gnt      out  1       fetch granted (combinational, IDLE only)
//   f_rvalid   out  1       one-cycle pulse: f_rdata valid
//   f_rdata    out  DATA_W  fetched byte, held until next fetch completes
//   d_req      in   1       data request, held until d_gnt
//   d_we       in   1       1=write, 0=read, valid with d_req
//   d_addr     in   ADDR_W  data address
//   d_wdata    in   DATA_W  write data
//   d_gnt      out  1       data granted (combinational, IDLE only)
//   d_rvalid   out  1       one-cycle completion pulse (reads and writes)
//   d_rdata    out  DATA_W  read byte; unchanged by writes
//   mem_addr   out  ADDR_W  external address, 0 when idle
//   mem_rd     out  1       external read strobe
//   mem_wr     out  1       external write strobe
//   mem_wdata  out  DATA_W  external write data, 0 unless mem_wr
//   mem_rdata  in   DATA_W  external read data
//   busy       out  1       high in any state except IDLE
// BEHAVIOUR
//   - States: IDLE -> ACCESS (RD_LATENCY+1 cycles, down-counter) -> RESP (1 cycle) -> IDLE.
//   - Reset: state IDLE; all outputs 0; f_rdata/d_rdata 0; latency and starve counters 0.
//   - IDLE cycle T: winner's gnt high in T; addr/we/wdata/owner latched at end of T.
//   - ACCESS: mem_addr = latched addr; mem_rd=!we or mem_wr=we for every ACCESS cycle; mem_wdata=wdata on writes.
//   - Last ACCESS cycle: read data sampled into owner's rdata register at its closing edge.
//   - RESP: owner's rvalid=1 for exactly one cycle; strobes low, mem_addr 0.
//   - Read latency req->rvalid = RD_LATENCY+2 cycles; one transaction per RD_LATENCY+3 cycles max.
//   - No grant outside IDLE; requests arriving while busy wait; req held after gnt = new request next IDLE.
//   - Priority: data wins ties unless starve_cnt >= STARVE_LIMIT, then fetch wins.
//   - starve_cnt: +1 (saturating at STARVE_LIMIT) on each d_gnt while f_req=1; cleared on f_gnt or f_req=0.
//   - Single requester always granted in the IDLE cycle it is seen.
//   - mem_addr/latched addr are plain ADDR_W registers; no arithmetic, no wrap concerns.
//   - Reset mid-transaction: immediate return to reset values; transaction dropped, no rvalid, no strobe.
// STRUCTURE
//   - Shared package quick_cpu_pkg: state encoding (IDLE/ACCESS/RESP), owner encoding (OWN_F/OWN_D),
//     default ADDR_W/DATA_W.
//   - One sub-module quick_mem_prio: combinational tie-break + starve counter (req inputs, gnt outputs).
//   - Remainder (FSM, latency counter, latches, rdata registers) inline.
// TESTING
//   1. Reset with f_req=1 held -> all outputs 0 during reset; first f_gnt in cycle after rst_n rises.
//   2. f_req, f_addr=0x05, mem_rdata=0x3C (RD_LATENCY=1) -> f_gnt@T, mem_rd/mem_addr=0x05 @T+1..T+2,
//      f_rvalid=1 with f_rdata=0x3C @T+3, idle @T+4.
//   3. f_req and d_req (read, 0x80) together -> d_gnt first; f_gnt at next IDLE; f_rdata unchanged by data read.
//   4. d_req held continuously with f_req held, STARVE_LIMIT=3 -> exactly 3 data grants then f_gnt.
//   5. d_we=1, d_addr=0x10, d_wdata=0xA5 -> mem_wr=1, mem_wdata=0xA5 for 2 cycles; d_rvalid pulse; d_rdata unchanged.
//   6. rst_n low during ACCESS -> strobes drop same cycle; no rvalid after release; busy=0.

Source files
------------

// File: rtl/quick_cpu_pkg.sv
// Shared types for the quick CPU memory path: arbiter state and transaction owner
// encodings, default bus widths and a counter-width helper.
package quick_cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Bits needed to hold the values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/quick_mem_prio.sv
// Fetch/data tie-break for the memory arbiter: data normally wins, but fetch is forced
// through once it has lost STARVE_LIMIT consecutive grants while still requesting.
module quick_mem_prio
  import quick_cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic f_req,
  input  logic d_req,
  output logic f_win,
  output logic d_win
);

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt >= LIMIT);

  always_comb begin
    f_win = arb_en && f_req && (!d_req || starved);
    d_win = arb_en && d_req && !(f_req && starved);
  end

  // Counts data grants taken while fetch was waiting; any fetch grant or a
  // withdrawn fetch request starts the count over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (d_win && f_req) begin
      if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end else if (f_win || !f_req) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/quick_mem_arbiter.sv
// Sole master of the external memory port: grants fetch or data in IDLE, drives the
// address/strobe for RD_LATENCY+1 cycles, samples read data and pulses the owner's rvalid.
module quick_mem_arbiter
  import quick_cpu_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LW = cnt_width(RD_LATENCY);
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LATENCY);

  state_t        state;
  owner_t        owner;
  logic [LW-1:0] lat_cnt;
  logic          f_win;
  logic          d_win;

  quick_mem_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_en(state == ST_IDLE),
    .f_req (f_req),
    .d_req (d_req),
    .f_win (f_win),
    .d_win (d_win)
  );

  // Grants are visible outputs only; gating them with rst_n keeps them low while
  // reset is held without routing the reset into any flop's data path.
  assign f_gnt = f_win && rst_n;
  assign d_gnt = d_win && rst_n;
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_F;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (d_win) begin
            state     <= ST_ACCESS;
            owner     <= OWN_D;
            lat_cnt   <= LAT_INIT;
            mem_addr  <= d_addr;
            mem_rd    <= !d_we;
            mem_wr    <= d_we;
            mem_wdata <= d_we ? d_wdata : '0;
          end else if (f_win) begin
            state     <= ST_ACCESS;
            owner     <= OWN_F;
            lat_cnt   <= LAT_INIT;
            mem_addr  <= f_addr;
            mem_rd    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
          end
        end
        ST_ACCESS: begin
          if (lat_cnt == '0) begin
            state     <= ST_RESP;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            // Writes complete without touching the requester's read register.
            if (owner == OWN_F) begin
              f_rvalid <= 1'b1;
              if (!mem_wr) f_rdata <= mem_rdata;
            end else begin
              d_rvalid <= 1'b1;
              if (!mem_wr) d_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quick_mem_arbiter.sv
// Bench for quick_mem_arbiter: directed table of single transactions, hand sequences for
// reset, starvation and mid-access reset, then random traffic against a transaction-level model.
module tb_quick_mem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 1;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr, busy;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          use_mem = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  logic [DW-1:0] phys_mem [256];
  logic [DW-1:0] ref_mem  [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rdata = use_mem ? phys_mem[mem_addr] : fixed_rdata;

  quick_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] rdata;
    logic          exp_fg;
    logic          exp_dg;
    logic [AW-1:0] exp_addr;
    logic          exp_rd;
    logic          exp_wr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_frd;
    logic [DW-1:0] exp_drd;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read on the falling edge.
  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_gnt"}, f_gnt, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_f_rvalid"}, f_rvalid, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_f_rdata"}, f_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      drive_edge();
      sample();
      if (!busy) done = 1'b1;
    end
    chk({tag, "_idle_timeout"}, done, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    drive_edge();
    f_req = v.f_req; f_addr = v.f_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    fixed_rdata = v.rdata;
    sample();
    chk({t, "_f_gnt"}, f_gnt, v.exp_fg);
    chk({t, "_d_gnt"}, d_gnt, v.exp_dg);
    chk({t, "_busy_grant"}, busy, 0);
    for (int k = 0; k <= LAT; k++) begin
      drive_edge();
      idle_inputs();
      sample();
      chk({t, "_acc_addr"}, mem_addr, v.exp_addr);
      chk({t, "_acc_rd"}, mem_rd, v.exp_rd);
      chk({t, "_acc_wr"}, mem_wr, v.exp_wr);
      chk({t, "_acc_wdata"}, mem_wdata, v.exp_wdata);
      chk({t, "_acc_busy"}, busy, 1);
      chk({t, "_acc_rvalid"}, {f_rvalid, d_rvalid}, 0);
    end
    drive_edge();
    sample();
    chk({t, "_resp_f_rvalid"}, f_rvalid, v.exp_fg);
    chk({t, "_resp_d_rvalid"}, d_rvalid, v.exp_dg);
    chk({t, "_resp_f_rdata"}, f_rdata, v.exp_frd);
    chk({t, "_resp_d_rdata"}, d_rdata, v.exp_drd);
    chk({t, "_resp_strobes"}, {mem_rd, mem_wr}, 0);
    chk({t, "_resp_addr"}, mem_addr, 0);
    chk({t, "_resp_busy"}, busy, 1);
    drive_edge();
    sample();
    chk({t, "_after_busy"}, busy, 0);
    chk({t, "_after_rvalid"}, {f_rvalid, d_rvalid}, 0);
  endtask

  // Transaction-level model state for the random phase.
  int            next_free, g_cyc, starve;
  bit            has_cur, cur_d, cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, cur_data, exp_frd, exp_drd;

  initial begin
    int  nd;
    bit  seen, idle, ef, ed, in_acc, in_resp, f_done, d_done;

    f_req = 1'b1; f_addr = 8'h05; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; fixed_rdata = 8'h3C;

    // Reset held with a pending fetch: nothing may leak out.
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      sample();
      chk_all_zero("reset");
    end
    drive_edge();
    rst_n = 1'b1;
    sample();
    chk("post_reset_f_gnt", f_gnt, 1);
    chk("post_reset_d_gnt", d_gnt, 0);
    drive_edge();
    idle_inputs();
    sample();
    wait_idle("post_reset");

    vecs[0] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3C,
                1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 8'h77,
                1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h77};
    vecs[2] = '{1'b1, 8'h06, 1'b1, 1'b0, 8'h80, 8'h00, 8'h11,
                1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h11};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5, 8'hEE,
                1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h11};
    vecs[4] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,
                1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 8'h11};
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Both requesters held: data wins LIM times, then fetch is forced through.
    nd = 0;
    seen = 1'b0;
    fixed_rdata = 8'h99;
    for (int i = 0; i < 40 && !seen; i++) begin
      drive_edge();
      if (i == 0) begin
        f_req = 1'b1; f_addr = 8'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      end
      sample();
      if (d_gnt) nd++;
      if (f_gnt) seen = 1'b1;
    end
    chk("starve_f_gnt_seen", seen, 1);
    chk("starve_d_grants", nd, LIM);
    idle_inputs();
    wait_idle("starve");

    // Reset during the second ACCESS cycle of a data read.
    drive_edge();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h33; fixed_rdata = 8'h5A;
    sample();
    chk("midrst_d_gnt", d_gnt, 1);
    drive_edge();
    idle_inputs();
    sample();
    chk("midrst_acc_rd", mem_rd, 1);
    chk("midrst_acc_addr", mem_addr, 8'h33);
    drive_edge();
    rst_n = 1'b0;
    sample();
    chk_all_zero("midrst_in_reset");
    drive_edge();
    sample();
    drive_edge();
    rst_n = 1'b1;
    sample();
    for (int i = 0; i < 5; i++) begin
      drive_edge();
      sample();
      chk_all_zero("midrst_after");
    end

    // Random traffic against the transaction-level model.
    use_mem = 1'b1;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = DW'($urandom_range(0, 255));
      ref_mem[i]  = phys_mem[i];
    end
    next_free = 0; starve = 0; has_cur = 1'b0;
    exp_frd = '0; exp_drd = '0;
    f_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 800; c++) begin
      drive_edge();
      if (f_done) f_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (!f_req && $urandom_range(0, 99) < 35) begin
        f_req = 1'b1; f_addr = AW'($urandom_range(0, 15));
      end
      if (!d_req && $urandom_range(0, 99) < 35) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 15)); d_wdata = DW'($urandom_range(0, 255));
      end
      sample();

      idle    = (c >= next_free);
      ef      = idle && f_req && (!d_req || starve >= LIM);
      ed      = idle && d_req && !ef;
      in_acc  = has_cur && (c >= g_cyc + 1) && (c <= g_cyc + LAT + 1);
      in_resp = has_cur && (c == g_cyc + LAT + 2);
      if (in_resp && !cur_we) begin
        if (cur_d) exp_drd = cur_data;
        else exp_frd = cur_data;
      end

      chk("rnd_f_gnt", f_gnt, ef);
      chk("rnd_d_gnt", d_gnt, ed);
      chk("rnd_busy", busy, !idle);
      chk("rnd_mem_addr", mem_addr, in_acc ? cur_addr : '0);
      chk("rnd_mem_rd", mem_rd, in_acc && !cur_we);
      chk("rnd_mem_wr", mem_wr, in_acc && cur_we);
      chk("rnd_mem_wdata", mem_wdata, (in_acc && cur_we) ? cur_wdata : '0);
      chk("rnd_f_rvalid", f_rvalid, in_resp && !cur_d);
      chk("rnd_d_rvalid", d_rvalid, in_resp && cur_d);
      chk("rnd_f_rdata", f_rdata, exp_frd);
      chk("rnd_d_rdata", d_rdata, exp_drd);

      if (mem_wr) phys_mem[mem_addr] = mem_wdata;

      if (ed && f_req) starve = (starve < LIM) ? starve + 1 : LIM;
      else if (ef || !f_req) starve = 0;

      if (ef || ed) begin
        has_cur   = 1'b1;
        g_cyc     = c;
        next_free = c + LAT + 3;
        cur_d     = ed;
        cur_we    = ed && d_we;
        cur_addr  = ed ? d_addr : f_addr;
        cur_wdata = d_wdata;
        if (cur_we) ref_mem[cur_addr] = cur_wdata;
        else cur_data = ref_mem[cur_addr];
      end
      f_done = ef;
      d_done = ed;
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
